mb128_host: RTL and testbench

- Initiator side of the Memory Base 128 / Save-kun joypad-port protocol.
- Bit-bangs the Clr line (o_Clk) and the Sel line (o_Data) toward an MB128 responder and samples its returned nibble.
- Takes one command at a time: read or write, 10-bit 128-byte block address, byte count, trailing bit count.
- Streams payload bytes over valid/ready handshakes; used by the save-manager/loader path and as the bench driver for the MB128 responder.

---
 rtl/mb128_host.sv | 223 ++++++++++++++++++++++
 tb/tb_mb128_host.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb128_host.sv
// mb128_host: initiator for the Memory Base 128 joypad-port protocol.
//
// Toggles the Clr line (o_Clk) and drives the Sel line (o_Data) one bit cell
// at a time. A bit cell is HALF_PERIOD cycles with o_Clk low, then
// HALF_PERIOD cycles with o_Clk high. o_Data changes only at the start of a
// cell. The device response is sampled on the last high cycle of the cell.
// A transaction is: sync byte 0xA8, ack, ident, request bit, 10-bit address,
// 3-bit trailing bit count, 17-bit byte count, payload, then a low trailer
// (3 cells after a read, 5 after a write).
//
// Ports
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   cmd_*                   command handshake and fields (rd, addr, bytes, bits)
//   wr_data/valid/ready     write payload; wr_ready pulses when a byte is taken
//   rd_data/valid           read payload; rd_valid is a one-cycle pulse
//   busy, done, err         status; err is meaningful while done is high
//   o_Clk, o_Data           Clr and Sel lines to the device
//   i_Active, i_Data        device-present flag and returned nibble
//
// Configuration macro: MB128_HOST_CHECK_EN
//   defined   - check i_Active after sync, ident bit, and request echo;
//               a failed check aborts with err 1, 2 or 3
//   undefined - no checks, err is always 0, every transaction runs fully
module mb128_host #(
    parameter int HALF_PERIOD = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [9:0]  cmd_addr,
    input  logic [16:0] cmd_bytes,
    input  logic [2:0]  cmd_bits,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        o_Clk,
    output logic        o_Data,
    input  logic        i_Active,
    input  logic [3:0]  i_Data
);
    localparam int              PW       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0]   PH_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [7:0]      SYNC_PAT = 8'hA8;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_ACK, S_IDENT, S_REQ, S_ADDR, S_LENBITS,
        S_LENBYTES, S_DATA, S_WAITW, S_TRAIL, S_DONE
    } state_t;

    typedef struct packed {
        logic       rd;
        logic [9:0] addr;
        logic [2:0] bits;
    } cmd_t;

    state_t        state, state_n;
    cmd_t          cmd_q;
    logic [16:0]   bytes_left;   // sent as the length field, then counts down in DATA
    logic [4:0]    bit_cnt;      // bit index within the current field / byte
    logic          ph_hi;
    logic [PW-1:0] ph_cnt;
    logic [7:0]    wsh;
    logic [7:0]    acc;
    logic [7:0]    acc_n;
    logic [1:0]    err_q, err_n;
    logic          rej_q;

    logic in_cell, sample, zero_cmd, accept, full_byte, byte_end, more;

    // Some nibble bits (and i_Active without checks) are never looked at.
    logic unused_in;
    assign unused_in = &{1'b0, i_Active, i_Data[3], i_Data[2], i_Data[1]};

    always_comb begin
        in_cell   = (state inside {S_SYNC, S_ACK, S_IDENT, S_REQ, S_ADDR, S_LENBITS,
                                   S_LENBYTES, S_DATA, S_TRAIL});
        sample    = in_cell && ph_hi && (ph_cnt == PH_LAST);
        zero_cmd  = (cmd_bytes == 17'd0) && (cmd_bits == 3'd0);
        accept    = (state == S_IDLE) && cmd_valid && !zero_cmd;
        // Full bytes go first; once they are used up only the partial byte remains.
        full_byte = (bytes_left != 17'd0);
        byte_end  = full_byte ? (bit_cnt == 5'd7) : (bit_cnt == {2'b00, cmd_q.bits} - 5'd1);
        more      = full_byte && ((bytes_left != 17'd1) || (cmd_q.bits != 3'd0));
        acc_n     = acc | ({7'd0, i_Data[0]} << bit_cnt[2:0]);
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid) err_n = 2'd0;
                if (accept) state_n = S_SYNC;
            end
            S_SYNC: if (sample && bit_cnt == 5'd7) begin
                state_n = S_ACK;
`ifdef MB128_HOST_CHECK_EN
                if (!i_Active) begin
                    state_n = S_DONE;
                    err_n   = 2'd1;
                end
`endif
            end
            S_ACK: if (sample) state_n = S_IDENT;
            S_IDENT: if (sample) begin
                state_n = S_REQ;
`ifdef MB128_HOST_CHECK_EN
                if (!i_Data[2]) begin
                    state_n = S_DONE;
                    err_n   = 2'd2;
                end
`endif
            end
            S_REQ: if (sample) state_n = S_ADDR;
            S_ADDR: if (sample && bit_cnt == 5'd9) state_n = S_LENBITS;
            S_LENBITS: if (sample && bit_cnt == 5'd2) state_n = S_LENBYTES;
            S_LENBYTES: if (sample && bit_cnt == 5'd16) begin
                state_n = cmd_q.rd ? S_DATA : S_WAITW;
`ifdef MB128_HOST_CHECK_EN
                if (i_Data[0] != cmd_q.rd) begin
                    state_n = S_DONE;
                    err_n   = 2'd3;
                end
`endif
            end
            S_DATA: if (sample && byte_end)
                state_n = !more ? S_TRAIL : (cmd_q.rd ? S_DATA : S_WAITW);
            // Write byte stall: clock held low, no cell in progress.
            S_WAITW: if (wr_valid) state_n = S_DATA;
            S_TRAIL: if (sample && bit_cnt == (cmd_q.rd ? 5'd2 : 5'd4)) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q      <= '0;
            bytes_left <= '0;
            bit_cnt    <= '0;
            ph_hi      <= 1'b0;
            ph_cnt     <= '0;
            wsh        <= '0;
            acc        <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err_q      <= '0;
            rej_q      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err_q    <= err_n;
            rej_q    <= (state == S_IDLE) && cmd_valid && zero_cmd;

            if (!in_cell) begin
                ph_hi  <= 1'b0;
                ph_cnt <= '0;
            end else if (ph_cnt == PH_LAST) begin
                ph_hi  <= !ph_hi;
                ph_cnt <= '0;
            end else begin
                ph_cnt <= ph_cnt + 1'b1;
            end

            if (accept) begin
                cmd_q      <= '{rd: cmd_rd, addr: cmd_addr, bits: cmd_bits};
                bytes_left <= cmd_bytes;
                acc        <= '0;
            end

            if (sample)
                bit_cnt <= ((state_n != state) || (state == S_DATA && byte_end)) ? 5'd0
                                                                                 : bit_cnt + 5'd1;

            if (sample && state == S_DATA && byte_end && full_byte)
                bytes_left <= bytes_left - 17'd1;

            if (state == S_WAITW && wr_valid) wsh <= wr_data;

            if (sample && state == S_DATA && cmd_q.rd) begin
                if (byte_end) begin
                    rd_data  <= acc_n;
                    rd_valid <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc <= acc_n;
                end
            end
        end
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE) || rej_q;
        err       = err_q;
        wr_ready  = (state == S_WAITW) && wr_valid;
        o_Clk     = in_cell && ph_hi;
        o_Data    = 1'b0;
        case (state)
            S_SYNC:     o_Data = SYNC_PAT[bit_cnt[2:0]];
            S_IDENT:    o_Data = 1'b1;
            S_REQ:      o_Data = cmd_q.rd;
            S_ADDR:     o_Data = cmd_q.addr[bit_cnt[3:0]];
            S_LENBITS:  o_Data = cmd_q.bits[bit_cnt[1:0]];
            S_LENBYTES: o_Data = bytes_left[bit_cnt];
            S_DATA:     o_Data = !cmd_q.rd && wsh[bit_cnt[2:0]];
            default:    o_Data = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mb128_host.sv
module tb_mb128_host;
    localparam int HP = 4;
`ifdef MB128_HOST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rd = 1'b0;
    logic [9:0]  cmd_addr = '0;
    logic [16:0] cmd_bytes = '0;
    logic [2:0]  cmd_bits = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        cmd_ready, wr_ready, rd_valid, busy, done, o_Clk, o_Data;
    logic [7:0]  rd_data;
    logic [1:0]  err;
    logic        i_Active = 1'b1;
    logic [3:0]  i_Data = 4'b0100;

    initial forever #5 clk_sys = ~clk_sys;

    mb128_host #(.HALF_PERIOD(HP)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes), .cmd_bits(cmd_bits),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .o_Clk(o_Clk), .o_Data(o_Data), .i_Active(i_Active), .i_Data(i_Data)
    );

    typedef struct {
        logic [1:0]  err;
        int          edges;
        bit          hdr, rd, wr;
        logic [9:0]  addr;
        logic [2:0]  bits;
        logic [16:0] bytes;
        int          base, n;
    } exp_t;

    int          n_cmp = 0, n_bad = 0, n_done = 0;
    exp_t        exp_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  wfix_q[$];
    logic [7:0]  ref_mem[int];
    logic [7:0]  dev_mem[int];

    // device model state: 0 normal, 1 absent, 2 dead nibble, 3 wrong echo
    int          dev_mode = 0;
    int          edge_cnt = 0, viol = 0;
    logic        prev_clk = 1'b0;
    logic        p_rd = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [2:0]  p_bits = '0;
    logic [16:0] p_bytes = '0;
    logic [7:0]  sync_pat = 8'hA8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] rget(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 8'h00;
    endfunction
    function automatic logic [7:0] dget(input int i);
        return dev_mem.exists(i) ? dev_mem[i] : 8'h00;
    endfunction

    // Responder: reacts to each Clr rising edge (cell c), checks what the host
    // sent against the protocol and presents its answer for that cell.
    task automatic dev_cell(input int c, input logic d);
        int o, len, idx;
        logic [7:0] b;
        o = c - 41;
        len = int'(p_bytes) * 8 + int'(p_bits);
        idx = int'(p_addr) * 128 + o / 8;
        if (c < 8)        begin if (d !== sync_pat[c]) viol++; end
        else if (c == 8)  begin if (d !== 1'b0) viol++; end
        else if (c == 9)  begin if (d !== 1'b1) viol++; end
        else if (c == 10) p_rd = d;
        else if (c <= 20) p_addr[c-11] = d;
        else if (c <= 23) p_bits[c-21] = d;
        else if (c <= 40) p_bytes[c-24] = d;
        else if (o >= len || p_rd) begin
            if (d !== 1'b0) viol++;
        end else if (dev_mode == 0 || dev_mode == 3) begin
            b = dget(idx);
            b[o%8] = d;
            dev_mem[idx] = b;
        end
        if (dev_mode == 0 || dev_mode == 3) begin
            i_Active = 1'b1;
            i_Data   = 4'b0100;
            if (c == 40) i_Data[0] = p_rd ^ (dev_mode == 3);
            if (c >= 41 && p_rd && o < len) begin
                b = dget(idx);
                i_Data[0] = b[o%8];
            end
        end
    endtask

    // Responder + scoreboard monitor, both on the falling edge.
    initial forever begin
        exp_t x;
        logic [7:0] e;
        @(negedge clk_sys);
        if (dev_mode == 1)      begin i_Active = 1'b0; i_Data = 4'h0; end
        else if (dev_mode == 2) begin i_Active = 1'b1; i_Data = 4'h0; end
        if (!reset_n) begin
            edge_cnt = 0; viol = 0; prev_clk = 1'b0;
        end else begin
            if (o_Clk && !prev_clk) begin
                dev_cell(edge_cnt, o_Data);
                edge_cnt++;
            end
            prev_clk = o_Clk;
            if (cmd_valid && cmd_ready) begin edge_cnt = 0; viol = 0; end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_valid: got unexpected byte %0h expected none", rd_data);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_data", rd_data, e);
                end
            end
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL done: got unexpected done err=%0d expected none", err);
                end else begin
                    x = exp_q.pop_front();
                    chk("err", err, x.err);
                    chk("rising edges", edge_cnt, x.edges);
                    chk("o_Clk at done", o_Clk, 1'b0);
                    chk("protocol bits", viol, 0);
                    if (x.hdr) begin
                        chk("hdr rd", p_rd, x.rd);
                        chk("hdr addr", p_addr, x.addr);
                        chk("hdr bits", p_bits, x.bits);
                        chk("hdr bytes", p_bytes, x.bytes);
                    end
                    if (x.wr)
                        for (int i = 0; i < x.n; i++)
                            chk("written byte", dget(x.base + i), rget(x.base + i));
                end
            end
        end
    end

    task automatic wait_done();
        int start, t;
        start = n_done;
        t = 0;
        while (n_done == start && t < 20000) begin
            @(posedge clk_sys);
            t++;
        end
        if (n_done == start) begin
            n_cmp++; n_bad++;
            $display("FAIL done timeout: got no done expected done within 20000 cycles");
        end
    endtask

    task automatic feed(input logic [7:0] wb[$], input int wmax, input bit stall);
        int t, highs;
        for (int i = 0; i < wb.size(); i++) begin
            if (stall && i == 1) begin
                // hold the second byte back once the first byte's 8 cells are out
                t = 0;
                while ((edge_cnt < 49 || o_Clk) && t < 5000) begin @(negedge clk_sys); t++; end
                highs = 0;
                repeat (50) begin
                    @(negedge clk_sys);
                    if (o_Clk) highs++;
                end
                chk("o_Clk high cycles during stall", highs, 0);
                @(posedge clk_sys); #1;
            end else begin
                repeat ($urandom_range(wmax, 0)) @(posedge clk_sys);
                #1;
            end
            wr_valid = 1'b1;
            wr_data  = wb[i];
            t = 0;
            @(negedge clk_sys);
            while (!wr_ready && t < 5000) begin @(negedge clk_sys); t++; end
            if (!wr_ready) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_ready timeout: got 0 expected 1");
            end
            @(posedge clk_sys); #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic drive_cmd(input bit rd, input logic [9:0] addr, input int nb, input int nbits);
        @(posedge clk_sys); #1;
        cmd_rd = rd; cmd_addr = addr; cmd_bytes = 17'(nb); cmd_bits = 3'(nbits);
        cmd_valid = 1'b1;
        @(posedge clk_sys); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input bit rd, input logic [9:0] addr, input int nb, input int nbits,
                           input int wmax, input bit stall);
        exp_t x;
        logic [7:0] wb[$];
        logic [7:0] b, m;
        int total, nfull;
        total = nb * 8 + nbits;
        nfull = nb + ((nbits != 0) ? 1 : 0);
        x.err   = 2'd0;
        x.edges = (total == 0) ? 0 : 41 + total + (rd ? 3 : 5);
        if (CHK && total != 0) begin
            if (dev_mode == 1)      begin x.err = 2'd1; x.edges = 8;  end
            else if (dev_mode == 2) begin x.err = 2'd2; x.edges = 10; end
            else if (dev_mode == 3) begin x.err = 2'd3; x.edges = 41; end
        end
        x.hdr = (x.edges >= 41);
        x.rd = rd; x.addr = addr; x.bits = 3'(nbits); x.bytes = 17'(nb);
        x.wr = !rd && x.err == 2'd0 && total != 0;
        x.base = int'(addr) * 128;
        x.n = nfull;
        for (int i = 0; i < nfull; i++) begin
            m = (i == nb) ? 8'((1 << nbits) - 1) : 8'hFF;
            if (rd) begin
                if (x.err == 2'd0)
                    rd_q.push_back((dev_mode == 1 || dev_mode == 2) ? 8'h00 : (rget(x.base + i) & m));
            end else begin
                b = (wfix_q.size() != 0) ? wfix_q.pop_front() : 8'($urandom);
                wb.push_back(b);
                if (x.wr) ref_mem[x.base + i] = (rget(x.base + i) & ~m) | (b & m);
            end
        end
        exp_q.push_back(x);
        drive_cmd(rd, addr, nb, nbits);
        if (!rd && total != 0) begin
            fork
                feed(wb, wmax, stall);
                wait_done();
            join
        end else begin
            wait_done();
        end
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        ref_mem[a] = v;
        dev_mem[a] = v;
    endtask

    initial begin
        int t;
        logic [9:0] ra;
        int nb, nbits;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset o_Clk", o_Clk, 1'b0);
        chk("reset o_Data", o_Data, 1'b0);
        chk("reset cmd_ready", cmd_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 2'd0);
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset wr_ready", wr_ready, 1'b0);
        chk("reset rd_data", rd_data, 8'h00);
        reset_n = 1'b1;

        preload(32'h180, 8'h55);
        preload(32'h181, 8'hC3);
        preload(32'h081, 8'hFF);
        run_cmd(1'b1, 10'h003, 2, 0, 0, 1'b0);

        wfix_q.push_back(8'hA5);
        wfix_q.push_back(8'h06);
        run_cmd(1'b0, 10'h001, 1, 3, 3, 1'b0);
        chk("mem 0x080", dget(32'h080), 8'hA5);
        chk("mem 0x081", dget(32'h081), 8'hFE);

        run_cmd(1'b0, 10'h02A, 2, 0, 0, 1'b1);

        // zero-length command is refused with a done pulse
        run_cmd(1'b1, 10'h005, 0, 0, 0, 1'b0);
        #1;
        chk("cmd_ready after refused cmd", cmd_ready, 1'b1);

        dev_mode = 1; run_cmd(1'b1, 10'h007, 1, 0, 0, 1'b0);
        dev_mode = 2; run_cmd(1'b1, 10'h007, 1, 5, 0, 1'b0);
        dev_mode = 3; run_cmd(1'b1, 10'h003, 2, 0, 0, 1'b0);
        dev_mode = 0;

        // reset during ADDR
        drive_cmd(1'b1, 10'h003, 2, 0);
        t = 0;
        while (edge_cnt < 15 && t < 5000) begin @(negedge clk_sys); t++; end
        @(posedge clk_sys); #1;
        reset_n = 1'b0;
        #1;
        chk("mid-reset o_Clk", o_Clk, 1'b0);
        chk("mid-reset o_Data", o_Data, 1'b0);
        chk("mid-reset cmd_ready", cmd_ready, 1'b1);
        chk("mid-reset busy", busy, 1'b0);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        run_cmd(1'b1, 10'h003, 2, 0, 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            ra = 10'($urandom);
            nb = $urandom_range(3, 0);
            nbits = $urandom_range(7, 0);
            if (nb == 0 && nbits == 0) nbits = 1;
            for (int i = 0; i < 4; i++) preload(int'(ra) * 128 + i, 8'($urandom));
            run_cmd(1'($urandom), ra, nb, nbits, 5, 1'b0);
        end

        repeat (4) @(posedge clk_sys);
        chk("read queue drained", rd_q.size(), 0);
        chk("done queue drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
